// File: rtl/cpu_step_monitor.sv
// Debug monitor for 6502 bring-up: generates the CPU RDY enable (free-run or
// debounced single-step), halts on an address breakpoint, and shows the address.
module cpu_step_monitor #(
  parameter int DIVIDER         = 12_500_000,
  parameter int NUM_DIGITS      = 4,
  parameter int SCAN_DIV        = 25_000,
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int COMMON_ANODE    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_req,
  input  logic                  step_btn_n,
  input  logic                  bp_enable,
  input  logic [15:0]           bp_addr,
  input  logic [15:0]           cpu_addr,
  input  logic                  cpu_we,
  output logic                  cpu_rdy,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_sel_n,
  output logic                  halted,
  output logic                  bp_hit,
  output logic [3:0]            led
);

  localparam int DIV_W  = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int STR_W  = 20;

  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP} state_e;

  logic              sync1_q, sync2_q;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              btn_acc_q, btn_acc_d;
  logic              step_evt_q, step_evt_d;
  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              cap_q, run_prev_q;
  logic              bp_hit_q, bp_hit_d;
  logic [15:0]       addr_lat_q, addr_lat_d;
  logic              we_lat_q, we_lat_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [STR_W-1:0]  str_cnt_q, str_cnt_d;
  logic              bp_match, run_rise;
  logic [15:0]       nib_sh;
  logic [6:0]        glyph;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  // Accepted level flips only after DEBOUNCE_CYCLES samples disagreeing with it.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    btn_acc_d = btn_acc_q;
    if (sync2_q == btn_acc_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
      btn_acc_d = sync2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end
    step_evt_d = btn_acc_q & ~btn_acc_d;
  end

  assign bp_match = cap_q & bp_enable & (cpu_addr == bp_addr);
  assign run_rise = run_req & ~run_prev_q;

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    cpu_rdy   = 1'b0;
    case (state_q)
      S_HALT: begin
        div_cnt_d = '0;
        if (run_req && !bp_hit_q) state_d = S_RUN;
        else if (step_evt_q)      state_d = S_STEP;
      end
      S_STEP: begin
        cpu_rdy = 1'b1;
        state_d = S_HALT;
      end
      S_RUN: begin
        if (div_cnt_q == DIV_W'(DIVIDER - 1)) begin
          cpu_rdy   = 1'b1;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
        if (!run_req) begin
          state_d   = S_HALT;
          div_cnt_d = '0;
        end
      end
      default: state_d = S_HALT;
    endcase
    // A breakpoint hit overrides everything, including a same-cycle run request.
    if (bp_match) begin
      state_d   = S_HALT;
      div_cnt_d = '0;
    end
  end

  always_comb begin
    bp_hit_d   = bp_hit_q;
    addr_lat_d = addr_lat_q;
    we_lat_d   = we_lat_q;
    if (bp_match)      bp_hit_d = 1'b1;
    else if (run_rise) bp_hit_d = 1'b0;
    if (cap_q) begin
      addr_lat_d = cpu_addr;
      we_lat_d   = cpu_we;
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    str_cnt_d = str_cnt_q;
    if (cpu_rdy)                 str_cnt_d = '1;
    else if (str_cnt_q != '0)    str_cnt_d = str_cnt_q - STR_W'(1);
    nib_sh = addr_lat_q >> {idx_q, 2'b00};
    glyph  = hex_glyph(nib_sh[3:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      deb_cnt_q  <= '0;
      btn_acc_q  <= 1'b1;
      step_evt_q <= 1'b0;
      state_q    <= S_HALT;
      div_cnt_q  <= '0;
      cap_q      <= 1'b0;
      run_prev_q <= 1'b0;
      bp_hit_q   <= 1'b0;
      addr_lat_q <= '0;
      we_lat_q   <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      str_cnt_q  <= '0;
    end else begin
      sync1_q    <= step_btn_n;
      sync2_q    <= sync1_q;
      deb_cnt_q  <= deb_cnt_d;
      btn_acc_q  <= btn_acc_d;
      step_evt_q <= step_evt_d;
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      cap_q      <= cpu_rdy;
      run_prev_q <= run_req;
      bp_hit_q   <= bp_hit_d;
      addr_lat_q <= addr_lat_d;
      we_lat_q   <= we_lat_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      str_cnt_q  <= str_cnt_d;
    end
  end

  assign seg         = (COMMON_ANODE != 0) ? ~glyph : glyph;
  assign digit_sel_n = ~(NUM_DIGITS'(1) << idx_q);
  assign halted      = (state_q == S_HALT);
  assign bp_hit      = bp_hit_q;
  assign led         = {we_lat_q, bp_hit_q, halted, cpu_rdy | (str_cnt_q != '0)};

endmodule

// File: doc/cpu_step_monitor.md
# cpu_step_monitor

Parametrised CPU debug monitor sitting between the board I/O and the 6502 core in bring-up builds. It generates the CPU `RDY` clock-enable (free-run at a divided rate, or single-step from a debounced button) and halts on an address breakpoint. It also shows the CPU address on a multiplexed multi-digit 7-segment display and on status LEDs.

## Interface
- `DIVIDER`, 12_500_000: `clk` cycles between free-run `cpu_rdy` pulses (≥2).
- `NUM_DIGITS`, 4: display digits, 1..4; digit i shows `cpu_addr[4i+3:4i]`.
- `SCAN_DIV`, 25_000: `clk` cycles per digit in the scan.
- `DEBOUNCE_CYCLES`, 250_000: cycles the step button must be stable before it is accepted.
- `COMMON_ANODE`, 1: 1 = segment outputs active-low, 0 = active-high.

- `clk`  in  1  system clock (25 MHz)
- `rst_n`  in  1  asynchronous, active-low reset
- `run_req`  in  1  synchronous level; 1 = free-run requested, 0 = halt/step mode
- `step_btn_n`  in  1  raw asynchronous step button, active-low
- `bp_enable`  in  1  breakpoint enable
- `bp_addr`  in  16  breakpoint address
- `cpu_addr`  in  16  CPU address bus (`AB`)
- `cpu_we`  in  1  CPU write strobe
- `cpu_rdy`  out  1  one-cycle clock-enable to the CPU `RDY`
- `seg`  out  7  segments {g,f,e,d,c,b,a}; polarity set by `COMMON_ANODE`
- `digit_sel_n`  out  NUM_DIGITS  one-hot, active-low digit enable
- `halted`  out  1  1 in HALT state
- `bp_hit`  out  1  sticky breakpoint-hit flag
- `led`  out  4  {`cpu_we_lat`, `bp_hit`, `halted`, `cpu_rdy` stretched}

## Operation
- Step input: 2-flop synchroniser, then a debounce counter. The accepted level changes only after `DEBOUNCE_CYCLES` consecutive equal synchronised samples. A step event is a 1→0 transition of the accepted level (press).
- FSM states: HALT (reset state), RUN, STEP.
  - HALT: `cpu_rdy`=0. If `run_req`=1 and `bp_hit`=0, go to RUN. Else, on a step event, go to STEP.
  - STEP: `cpu_rdy`=1 for exactly one cycle, then HALT. Step events that arrive during STEP are dropped.
  - RUN: the divider counter counts 0..DIVIDER-1. On terminal count, `cpu_rdy`=1 for one cycle and the counter wraps to 0. If `run_req`=0, go to HALT and clear the counter. Step events are ignored.
- Address latch: in the cycle after any `cpu_rdy` pulse, capture `cpu_addr` into `addr_lat` and `cpu_we` into `cpu_we_lat`.
- Breakpoint check: done in the same cycle as the capture. If `bp_enable`=1 and `cpu_addr`==`bp_addr`, set `bp_hit` and force the FSM to HALT. This applies in RUN and in STEP.
- `bp_hit` clears only on a 0→1 edge of `run_req`. That edge then enters RUN in the following cycle.
- If a breakpoint hit and a `run_req` rising edge occur in the same cycle, the hit wins: `bp_hit`=1 and the state is HALT.
- Display: a scan counter advances the digit index every `SCAN_DIV` cycles, wrapping at `NUM_DIGITS-1`.
  - `digit_sel_n` = ~(1<<index).
  - `seg` = the hex glyph of nibble[index] of `addr_lat`. Glyphs 0-9, A, b, C, d, E, F.
  - The glyph is inverted when `COMMON_ANODE`=1.
- LED stretch: `led[0]` goes high on `cpu_rdy` and stays high for 2^20 cycles, so the pulse is visible.

## Timing
- Reset values (asynchronous):
  - state=HALT; `cpu_rdy`=0; `halted`=1; `bp_hit`=0.
  - `addr_lat`=0x0000; `cpu_we_lat`=0.
  - Digit index 0, so `digit_sel_n` = all ones except bit0=0.
  - `seg` = glyph "0": 7'b1000000 (anode) / 7'b0111111 (cathode).
  - All counters 0; debouncer accepted level=1 (released).
- Free-run period is exactly `DIVIDER` cycles. The first `cpu_rdy` comes `DIVIDER` cycles after entering RUN.
- Step latency: the step event is registered, then STEP is entered on the next cycle. `cpu_rdy` is high in the STEP cycle, i.e. 1 cycle after the event.
- Address capture and breakpoint evaluation happen 1 cycle after `cpu_rdy`. `halted` rises 1 cycle after that, with no second `cpu_rdy` in between. This holds because `DIVIDER`≥2.
- `rst_n` mid-step or mid-run: the `cpu_rdy` pulse is aborted immediately and all state returns to reset values.
- Counter widths: `$clog2` of the terminal value, minimum 1 bit. No counter overflows.

## Test plan
Bench parameters: `DIVIDER`=4, `DEBOUNCE_CYCLES`=3, `SCAN_DIV`=2, `NUM_DIGITS`=4, `COMMON_ANODE`=1.

1. Reset and run: release `rst_n`, hold `run_req`=0 for 20 cycles → `cpu_rdy` stays 0 and `halted`=1. Raise `run_req` → `cpu_rdy` pulses every 4 cycles, each pulse 1 cycle wide.
2. Single-step debounce:
   - Bounce `step_btn_n` 1-0-1-0 with 1-cycle glitches, then hold it low for 10 cycles.
   - Required: exactly one `cpu_rdy` pulse, within 6 cycles of the final fall.
   - Release and press again → a second single pulse.
3. Breakpoint: `bp_addr`=0xE003, `bp_enable`=1, run with `cpu_addr` incrementing on each `cpu_rdy` from 0xE000.
   - Required: `halted`=1 and `bp_hit`=1 after the pulse that produces 0xE003; no further `cpu_rdy`.
   - Toggle `run_req` 0→1 → `bp_hit` clears and pulses resume.
4. Display scan: `addr_lat`=0xE1A5.
   - `digit_sel_n` cycles 1110, 1101, 1011, 0111, changing every 2 cycles.
   - `seg` follows 5→7'b0010010, A→7'b0001000, 1→7'b1111001, E→7'b0000110.
5. Reset mid-run: assert `rst_n` low during a `cpu_rdy` pulse → `cpu_rdy`=0 in the same cycle, and all outputs take their reset values.
6. Simultaneous events: in the same cycle, present `cpu_addr`==`bp_addr` at capture and a `run_req` 0→1 edge → `bp_hit`=1 and state stays HALT.
